dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter addressSize, default 32, byte-address width.
REQ-002 Parameter dataSize, default 32, word width.
REQ-003 Parameter DEPTH, default 1024, number of words in the array (power of two).
REQ-004 Parameter RDY_DELAY, default 0, idle cycles between request sampling and mem_rdy (0..15).
REQ-005 Parameter LATENCY, default 2, cycles from the mem_rdy cycle to the valid cycle (1..15).
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 proc_req  input  1  initiator request; held high until mem_rdy is seen.
REQ-009 we  input  1  1 = store, 0 = load; sampled with proc_req.
REQ-010 addr  input  addressSize  byte address; sampled with proc_req.
REQ-011 wdata  input  dataSize  store data; sampled with proc_req.
REQ-012 mem_rdy  output  1  request accepted; one-cycle pulse.
REQ-013 valid  output  1  operation complete; one-cycle pulse.
REQ-014 rdata  output  dataSize  load data; meaningful while valid=1 and the request was a load.
REQ-015 err  output  1  access fault; meaningful only while valid=1.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ACCEPT, BUSY, RESP.
REQ-017 IDLE with proc_req=1 at an edge SHALL capture addr/we/wdata into internal registers, load the delay counter with RDY_DELAY, and enter ACCEPT.
REQ-018 ACCEPT SHALL decrement the counter each cycle; mem_rdy SHALL be 1 during the ACCEPT cycle in which the counter equals 0, and 0 otherwise.
REQ-019 If proc_req=0 at an ACCEPT edge while the counter is nonzero (abort), the FSM SHALL return to IDLE without accessing the array or pulsing mem_rdy or valid.
REQ-020 After the mem_rdy cycle, the FSM SHALL enter BUSY with its counter loaded so that valid rises exactly LATENCY cycles after the mem_rdy cycle.
REQ-021 In RESP, valid SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-022 proc_req SHALL be ignored outside IDLE; the earliest next acceptance is the edge that ends the valid cycle.
REQ-023 A fault SHALL be addr[1:0]!=0 or addr >= DEPTH*4.
REQ-024 For a fault, err SHALL be 1 in the valid cycle, the array SHALL not be written, and rdata SHALL be 0.
REQ-025 The word index SHALL be addr[$clog2(DEPTH)+1:2].
REQ-026 A non-faulting store SHALL write the captured wdata on the edge that enters RESP; rdata SHALL hold its previous value.
REQ-027 A non-faulting load SHALL present the array word in rdata during the valid cycle; rdata SHALL then hold until the next load response.
REQ-028 A store followed by a load to the same word SHALL return the stored data.
REQ-029 mem_rdy and valid SHALL never be 1 in the same cycle.
REQ-030 err SHALL be 0 whenever valid=0.

Reset
REQ-031 rst=0 SHALL immediately force the state to IDLE and clear mem_rdy, valid, err, rdata, the counters, and the captured registers, including mid-operation.
REQ-032 An in-flight store interrupted by reset SHALL not be written.
REQ-033 Array contents SHALL not be reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum and the parameter default constants.
REQ-035 Sub-module dmem_array SHALL implement the storage: synchronous write and registered read, single port.
REQ-036 dmem_responder SHALL contain the FSM, counters, capture registers, and fault decode.

Verification
REQ-037 RDY_DELAY=0, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> mem_rdy one cycle after each request, valid two cycles after mem_rdy, rdata=0xDEADBEEF, err=0.
REQ-038 RDY_DELAY=3: load request -> mem_rdy on the 4th cycle after sampling, then valid LATENCY cycles later.
REQ-039 Load 0x13, then store to DEPTH*4 -> each returns valid with err=1 and rdata=0; a subsequent load of the store target shows the word unchanged.
REQ-040 RDY_DELAY=3: proc_req dropped after 1 cycle -> no mem_rdy, no valid, FSM back in IDLE; the next request is served normally.
REQ-041 rst pulsed low during BUSY of a store to 0x20 -> all outputs 0 at once, no valid; a later load of 0x20 returns the pre-store value.
REQ-042 Back-to-back loads with proc_req held continuously -> second mem_rdy no earlier than the cycle after the first valid, and a valid for every mem_rdy.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and parameter defaults for the data-memory
//                responder (FSM state encoding, default geometry/timing).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_DEF     = 1024;
    localparam int RDY_DELAY_DEF = 0;
    localparam int LATENCY_DEF   = 2;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port word storage with synchronous write and a
//                registered read. Write takes priority over read; the read
//                register holds its value when no read is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset; one access (write or read) per edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder. Captures a load/store request,
//                acknowledges it with mem_rdy after RDY_DELAY idle cycles,
//                completes it LATENCY cycles later with a one-cycle valid,
//                and flags misaligned / out-of-range accesses with err.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int addressSize = ADDR_W_DEF,
    parameter int dataSize    = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int RDY_DELAY   = RDY_DELAY_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   proc_req,
    input  logic                   we,
    input  logic [addressSize-1:0] addr,
    input  logic [dataSize-1:0]    wdata,
    output logic                   mem_rdy,
    output logic                   valid,
    output logic [dataSize-1:0]    rdata,
    output logic                   err
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam logic [3:0] c_RDY_LOAD  = 4'(RDY_DELAY);
    // BUSY is entered the cycle after mem_rdy and RESP follows when the
    // counter hits zero, so LATENCY-2 extra BUSY cycles are needed. With
    // LATENCY=1 BUSY is skipped entirely.
    localparam logic [3:0] c_BUSY_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [addressSize:0] c_LIMIT = (addressSize + 1)'(DEPTH) << 2;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q,   cnt_d;
    logic [addressSize-1:0] addr_q,  addr_d;
    logic                   we_q,    we_d;
    logic [dataSize-1:0]    wdata_q, wdata_d;
    logic [dataSize-1:0]    rdata_q, rdata_d;

    logic                   w_fault;
    logic                   w_access;
    logic [c_IDX_W-1:0]     w_idx;
    logic [dataSize-1:0]    w_arr_rdata;
    logic [dataSize-1:0]    w_load_data;

    // Fault decode and word index, from the captured address.
    assign w_fault     = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= c_LIMIT);
    assign w_idx       = addr_q[c_IDX_W+1:2];
    assign w_load_data = w_fault ? '0 : w_arr_rdata;

    dmem_array #(
        .WIDTH (dataSize),
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (w_access &  we_q & ~w_fault),
        .re_i    (w_access & ~we_q & ~w_fault),
        .idx_i   (w_idx),
        .wdata_i (wdata_q),
        .rdata_o (w_arr_rdata)
    );

    // State, counter, capture and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, counter sequencing and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        w_access = 1'b0;
        mem_rdy  = 1'b0;
        valid    = 1'b0;
        err      = 1'b0;
        rdata    = rdata_q;

        case (state_q)
            IDLE: begin
                if (proc_req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = c_RDY_LOAD;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (cnt_q == 4'd0) begin
                    mem_rdy = 1'b1;
                    if (LATENCY <= 1) begin
                        // Array is accessed on the edge that enters RESP.
                        w_access = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = c_BUSY_LOAD;
                        state_d = BUSY;
                    end
                end else if (!proc_req) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    w_access = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                valid = 1'b1;
                err   = w_fault;
                if (!we_q) begin
                    rdata   = w_load_data;
                    rdata_d = w_load_data;
                end
                // A new request may be taken on the edge that ends valid.
                if (proc_req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = c_RDY_LOAD;
                    state_d = ACCEPT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Three instances
//                with different RDY_DELAY/LATENCY settings are exercised with
//                directed and random load/store traffic against a word-level
//                reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int TB_DEPTH = 64;
    localparam int NINST    = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NINST-1:0]      proc_req = '0;
    logic [NINST-1:0]      we_v = '0;
    logic [NINST-1:0][31:0] addr_v = '0;
    logic [NINST-1:0][31:0] wdata_v = '0;
    logic [NINST-1:0]      mem_rdy;
    logic [NINST-1:0]      valid;
    logic [NINST-1:0][31:0] rdata_v;
    logic [NINST-1:0]      err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [int];
    logic [31:0] last_rd [NINST];

    always #5 clk = ~clk;

    dmem_responder #(.addressSize(32), .dataSize(32), .DEPTH(TB_DEPTH), .RDY_DELAY(0), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .proc_req(proc_req[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
        .mem_rdy(mem_rdy[0]), .valid(valid[0]), .rdata(rdata_v[0]), .err(err[0]));

    dmem_responder #(.addressSize(32), .dataSize(32), .DEPTH(TB_DEPTH), .RDY_DELAY(3), .LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst), .proc_req(proc_req[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
        .mem_rdy(mem_rdy[1]), .valid(valid[1]), .rdata(rdata_v[1]), .err(err[1]));

    dmem_responder #(.addressSize(32), .dataSize(32), .DEPTH(TB_DEPTH), .RDY_DELAY(1), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst), .proc_req(proc_req[2]), .we(we_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
        .mem_rdy(mem_rdy[2]), .valid(valid[2]), .rdata(rdata_v[2]), .err(err[2]));

    function automatic int rdy_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(TB_DEPTH * 4));
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        return k * 1024 + int'((a >> 2) % TB_DEPTH);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Idle cycles: nothing may fire and rdata must hold its last load value.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NINST; k++) begin
                check("idle_rdy", mem_rdy[k], 1'b0);
                check("idle_valid", valid[k], 1'b0);
                check("idle_err", err[k], 1'b0);
                check("rdata_hold", rdata_v[k], last_rd[k]);
            end
        end
    endtask

    // One complete transaction on instance k, checked for latency and data.
    // With hold=1 proc_req stays high; the caller must issue the next op.
    task automatic do_op(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        int          cyc;
        bit          flt;
        int          key;
        logic [31:0] exp_rd;
        proc_req[k] = 1'b1;
        we_v[k]     = wr;
        addr_v[k]   = a;
        wdata_v[k]  = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!mem_rdy[k]) check("pre_rdy_valid", valid[k], 1'b0);
        end while (!mem_rdy[k] && cyc < 40);
        check("rdy_latency", 32'(cyc), 32'(rdy_of(k) + 1));
        check("rdy_valid_excl", valid[k], 1'b0);
        if (!hold) proc_req[k] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!valid[k]) begin
                check("busy_rdy", mem_rdy[k], 1'b0);
                check("busy_err", err[k], 1'b0);
            end
        end while (!valid[k] && cyc < 40);
        check("valid_latency", 32'(cyc), 32'(lat_of(k)));
        check("valid_rdy_excl", mem_rdy[k], 1'b0);
        flt = is_fault(a);
        key = key_of(k, a);
        if (wr) exp_rd = last_rd[k];
        else    exp_rd = flt ? 32'h0 : model[key];
        check(wr ? "err_st" : "err_ld", err[k], flt);
        check(wr ? "rdata_st" : "rdata_ld", rdata_v[k], exp_rd);
        if (!wr) last_rd[k] = exp_rd;
        else if (!flt) model[key] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = 32'($urandom_range(0, TB_DEPTH - 1)) << 2;
        if (r < 7)       return w;
        else if (r == 7) return w + 32'($urandom_range(1, 3));
        else if (r == 8) return w + 32'(TB_DEPTH * 4);
        else             return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        logic [31:0] v1;
        for (int k = 0; k < NINST; k++) last_rd[k] = 32'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NINST; k++) begin
            check("rst_rdy", mem_rdy[k], 1'b0);
            check("rst_valid", valid[k], 1'b0);
            check("rst_err", err[k], 1'b0);
            check("rst_rdata", rdata_v[k], 32'h0);
        end
        rst = 1'b1;
        idle(2);

        // Give every word a known value.
        for (int k = 0; k < NINST; k++)
            for (int i = 0; i < TB_DEPTH; i++)
                do_op(k, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Store then load, zero ready delay.
        do_op(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_op(0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("deadbeef", rdata_v[0], 32'hDEAD_BEEF);
        idle(2);

        // Ready delay of three cycles.
        do_op(1, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(1);

        // Faults: misaligned load, store just past the array (aliases word 0).
        do_op(0, 1'b0, 32'h13, 32'h0, 1'b0);
        do_op(0, 1'b1, 32'(TB_DEPTH * 4), 32'h1234_5678, 1'b0);
        do_op(0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1);

        // Abort while the ready delay is still counting.
        proc_req[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h8;
        @(negedge clk);
        check("abort_rdy", mem_rdy[1], 1'b0);
        proc_req[1] = 1'b0;
        idle(8);
        do_op(1, 1'b0, 32'h8, 32'h0, 1'b0);
        idle(1);

        // Reset in the middle of a store to 0x20.
        v1 = $urandom | 32'h1;
        do_op(0, 1'b1, 32'h20, v1, 1'b0);
        do_op(0, 1'b0, 32'h20, 32'h0, 1'b0);
        proc_req[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = ~v1;
        @(negedge clk);
        check("mid_rdy", mem_rdy[0], 1'b1);
        proc_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", mem_rdy[0], 1'b0);
        check("mid_rst_valid", valid[0], 1'b0);
        check("mid_rst_err", err[0], 1'b0);
        check("mid_rst_rdata", rdata_v[0], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NINST; k++) last_rd[k] = 32'h0;
        idle(5);
        do_op(0, 1'b0, 32'h20, 32'h0, 1'b0);
        check("rst_no_write", rdata_v[0], v1);
        idle(1);

        // Back-to-back loads with proc_req held high.
        for (int k = 0; k < NINST; k++) begin
            for (int j = 0; j < 4; j++)
                do_op(k, 1'b0, 32'(j * 8), 32'h0, j != 3);
            idle(1);
        end

        // Random traffic.
        for (int k = 0; k < NINST; k++) begin
            for (int j = 0; j < 40; j++) begin
                do_op(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                      ($urandom_range(0, 3) == 0) && (j != 39));
                if (!proc_req[k] && $urandom_range(0, 1) == 1)
                    idle($urandom_range(1, 2));
            end
            idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
